// File: rtl/a53_keystream_ctrl.sv
// -----------------------------------------------------------------------------
// a53_keystream_ctrl
//
// Sequences a single fixed-latency 64-bit KASUMI core through the A5/3 KGCORE
// chain, one pass at a time:
//   pass 0   : A     = KASUMI[Kc ^ 0x5555...](init_data)
//   pass n+1 : KSB_n = KASUMI[Kc](A ^ n ^ KSB_(n-1)), with KSB_(-1) = 0
// Each keystream block is presented on a valid/ready output port.
//
// Build option:
//   A53_KS_OVERLAP_EN - when defined, the next pass is issued on the cycle
//   after a block capture instead of waiting for the output handshake. If the
//   pass finishes while the output is still unaccepted, the capture stalls
//   with the core inputs held.
//
// Parameters:
//   LATENCY    cycles from a core input change to a capturable core_dout (1..255)
//   CNT_W      width of the block count / block counter (< 64)
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             one-cycle request, accepted only while idle
//   kc                cipher key, sampled on an accepted start
//   init_data         KGCORE initial value, used on an accepted start
//   num_blocks        number of keystream blocks, sampled on an accepted start
//   busy              high in every state except IDLE
//   core_kc/core_din  registered key/data to the KASUMI core
//   core_dout         KASUMI core result
//   ks_data/ks_valid/ks_ready/ks_last   keystream output handshake
//   done              one-cycle pulse at the end of a sequence
// -----------------------------------------------------------------------------
module a53_keystream_ctrl #(
   parameter int LATENCY = 16,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [63:0]      kc,
   input  logic [63:0]      init_data,
   input  logic [CNT_W-1:0] num_blocks,
   output logic             busy,
   output logic [63:0]      core_kc,
   output logic [63:0]      core_din,
   input  logic [63:0]      core_dout,
   output logic [63:0]      ks_data,
   output logic             ks_valid,
   input  logic             ks_ready,
   output logic             ks_last,
   output logic             done
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PRE_WAIT = 3'd1,
      GEN_WAIT = 3'd2,
      OUT      = 3'd3,
      FIN      = 3'd4
   } state_t;

   localparam logic [63:0]      KEY_MOD   = 64'h5555_5555_5555_5555;
   localparam logic [7:0]       WAIT_LAST = 8'(LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   // Data input of a keystream pass: A ^ zero-extended n ^ previous block.
   function automatic logic [63:0] chain_din(input logic [63:0]      a,
                                             input logic [CNT_W-1:0] n,
                                             input logic [63:0]      ksb_prev);
      chain_din = a ^ {{(64-CNT_W){1'b0}}, n} ^ ksb_prev;
   endfunction

   state_t           state_r, state_s;
   logic [7:0]       wait_cnt_r, wait_cnt_s;
   logic [63:0]      kc_r, kc_s;
   logic [CNT_W-1:0] num_r, num_s;
   logic [63:0]      a_r, a_s;
   logic [63:0]      ksb_r, ksb_s;
   logic [CNT_W-1:0] n_r, n_s;
   logic [63:0]      core_kc_r, core_kc_s;
   logic [63:0]      core_din_r, core_din_s;
   logic [63:0]      ks_data_r, ks_data_s;
   logic             ks_valid_r, ks_valid_s;
   logic             ks_last_r, ks_last_s;
   logic             busy_r, busy_s;
   logic             done_r, done_s;
   logic             handshake_s;
   logic             wait_done_s;
   logic [7:0]       wait_inc_s;
   logic [CNT_W-1:0] next_n_s;
`ifdef A53_KS_OVERLAP_EN
   // Set once the pass following the presented block has been issued.
   logic             issued_r, issued_s;
`endif

   assign busy     = busy_r;
   assign core_kc  = core_kc_r;
   assign core_din = core_din_r;
   assign ks_data  = ks_data_r;
   assign ks_valid = ks_valid_r;
   assign ks_last  = ks_last_r;
   assign done     = done_r;

   // Next-state and next-register computation for the sequencer.
   always_comb begin
      state_s     = state_r;
      wait_cnt_s  = wait_cnt_r;
      kc_s        = kc_r;
      num_s       = num_r;
      a_s         = a_r;
      ksb_s       = ksb_r;
      n_s         = n_r;
      core_kc_s   = core_kc_r;
      core_din_s  = core_din_r;
      ks_data_s   = ks_data_r;
      ks_valid_s  = ks_valid_r;
      ks_last_s   = ks_last_r;
`ifdef A53_KS_OVERLAP_EN
      issued_s    = issued_r;
`endif
      handshake_s = ks_valid_r & ks_ready;
      // The counter stops at its last value, so a stalled capture stays ready.
      wait_done_s = (wait_cnt_r == WAIT_LAST);
      wait_inc_s  = wait_done_s ? wait_cnt_r : (wait_cnt_r + 8'd1);
      next_n_s    = n_r + CNT_ONE;

      case (state_r)
         IDLE: begin
            if (start) begin
               if (num_blocks != CNT_ZERO) begin
                  kc_s       = kc;
                  num_s      = num_blocks;
                  a_s        = 64'd0;
                  ksb_s      = 64'd0;
                  n_s        = CNT_ZERO;
                  core_kc_s  = kc ^ KEY_MOD;
                  core_din_s = init_data;
                  wait_cnt_s = 8'd0;
                  state_s    = PRE_WAIT;
               end else begin
                  state_s    = FIN;
               end
            end else begin
               state_s = IDLE;
            end
         end

         PRE_WAIT: begin
            if (wait_done_s) begin
               a_s        = core_dout;
               n_s        = CNT_ZERO;
               core_kc_s  = kc_r;
               core_din_s = chain_din(core_dout, CNT_ZERO, 64'd0);
               wait_cnt_s = 8'd0;
               state_s    = GEN_WAIT;
            end else begin
               wait_cnt_s = wait_inc_s;
            end
         end

         GEN_WAIT: begin
            if (wait_done_s) begin
               ks_data_s  = core_dout;
               ks_valid_s = 1'b1;
               ks_last_s  = (n_r == (num_r - CNT_ONE));
               ksb_s      = core_dout;
`ifdef A53_KS_OVERLAP_EN
               issued_s   = 1'b0;
`endif
               state_s    = OUT;
            end else begin
               wait_cnt_s = wait_inc_s;
            end
         end

         OUT: begin
`ifdef A53_KS_OVERLAP_EN
            if (ks_last_r) begin
               if (handshake_s) begin
                  ks_valid_s = 1'b0;
                  ks_last_s  = 1'b0;
                  state_s    = FIN;
               end else begin
                  state_s = OUT;
               end
            end else if (!issued_r) begin
               // First cycle after a capture: launch the next pass right away.
               n_s        = next_n_s;
               core_din_s = chain_din(a_r, next_n_s, ksb_r);
               wait_cnt_s = 8'd0;
               issued_s   = 1'b1;
               if (handshake_s) begin
                  ks_valid_s = 1'b0;
                  state_s    = GEN_WAIT;
               end else begin
                  state_s = OUT;
               end
            end else begin
               wait_cnt_s = wait_inc_s;
               if (handshake_s) begin
                  if (wait_done_s) begin
                     // Output register frees this very cycle: capture into it.
                     ks_data_s  = core_dout;
                     ks_valid_s = 1'b1;
                     ks_last_s  = (n_r == (num_r - CNT_ONE));
                     ksb_s      = core_dout;
                     issued_s   = 1'b0;
                     state_s    = OUT;
                  end else begin
                     ks_valid_s = 1'b0;
                     state_s    = GEN_WAIT;
                  end
               end else begin
                  state_s = OUT;
               end
            end
`else
            if (handshake_s) begin
               ks_valid_s = 1'b0;
               ks_last_s  = 1'b0;
               if (ks_last_r) begin
                  state_s = FIN;
               end else begin
                  n_s        = next_n_s;
                  core_din_s = chain_din(a_r, next_n_s, ksb_r);
                  wait_cnt_s = 8'd0;
                  state_s    = GEN_WAIT;
               end
            end else begin
               state_s = OUT;
            end
`endif
         end

         FIN: begin
            state_s = IDLE;
         end

         default: begin
            state_s = IDLE;
         end
      endcase

      busy_s = (state_s != IDLE);
      done_s = (state_s == FIN);
   end

   // Sequencer state and output registers, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         wait_cnt_r <= 8'd0;
         kc_r       <= 64'd0;
         num_r      <= CNT_ZERO;
         a_r        <= 64'd0;
         ksb_r      <= 64'd0;
         n_r        <= CNT_ZERO;
         core_kc_r  <= 64'd0;
         core_din_r <= 64'd0;
         ks_data_r  <= 64'd0;
         ks_valid_r <= 1'b0;
         ks_last_r  <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
`ifdef A53_KS_OVERLAP_EN
         issued_r   <= 1'b0;
`endif
      end else begin
         state_r    <= state_s;
         wait_cnt_r <= wait_cnt_s;
         kc_r       <= kc_s;
         num_r      <= num_s;
         a_r        <= a_s;
         ksb_r      <= ksb_s;
         n_r        <= n_s;
         core_kc_r  <= core_kc_s;
         core_din_r <= core_din_s;
         ks_data_r  <= ks_data_s;
         ks_valid_r <= ks_valid_s;
         ks_last_r  <= ks_last_s;
         busy_r     <= busy_s;
         done_r     <= done_s;
`ifdef A53_KS_OVERLAP_EN
         issued_r   <= issued_s;
`endif
      end
   end

endmodule

// File: tb/tb_a53_keystream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_a53_keystream_ctrl
//
// Self-checking bench for a53_keystream_ctrl. A stand-in KASUMI core
// (dout = din ^ key) sits behind the controller; its output reflects inputs
// changed at edge T when sampled at edge T+LAT. Expected keystream blocks are
// computed from the KGCORE chain rules directly.
// -----------------------------------------------------------------------------
module tb_a53_keystream_ctrl;

   localparam int          LAT     = 16;
   localparam logic [63:0] KEY_MOD = 64'h5555_5555_5555_5555;

   logic        clk;
   logic        rst;
   logic        start;
   logic [63:0] kc;
   logic [63:0] init_data;
   logic [7:0]  num_blocks;
   logic        busy;
   logic [63:0] core_kc;
   logic [63:0] core_din;
   logic [63:0] core_dout;
   logic [63:0] ks_data;
   logic        ks_valid;
   logic        ks_ready;
   logic        ks_last;
   logic        done;

   int n_checks = 0;
   int n_errors = 0;

   a53_keystream_ctrl #(.LATENCY(LAT), .CNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .kc         (kc),
      .init_data  (init_data),
      .num_blocks (num_blocks),
      .busy       (busy),
      .core_kc    (core_kc),
      .core_din   (core_din),
      .core_dout  (core_dout),
      .ks_data    (ks_data),
      .ks_valid   (ks_valid),
      .ks_ready   (ks_ready),
      .ks_last    (ks_last),
      .done       (done)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Stand-in cipher used by both the core model and the expectations.
   function automatic logic [63:0] kasumi_ref(input logic [63:0] din, input logic [63:0] key);
      return din ^ key;
   endfunction

   // Core model: LAT-1 register stages, so inputs set at edge T are on core_dout at edge T+LAT.
   logic [63:0] core_pipe [0:LAT-2];
   always @(posedge clk) begin
      core_pipe[0] <= kasumi_ref(core_din, core_kc);
      for (int i = 1; i < LAT - 1; i++) core_pipe[i] <= core_pipe[i-1];
   end
   assign core_dout = core_pipe[LAT-2];

   // Single comparison point: counts, and reports any mismatch.
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One full sequence. mode 0: ready always high, 1: ready low for 40 cycles on
   // the first block, 2: random ready, 3: ready high plus a start pulse while busy.
   task automatic run_seq(input logic [63:0] k, input logic [63:0] iv,
                          input logic [7:0] nb, input int mode);
      logic [63:0] exp_blk [$];
      logic [63:0] a_val, prev, held_data, held_din;
      logic        holding, held_last;
      int          c, first_v, prev_hs, last_hs, done_c, done_cnt, busy_cnt, idx, budget;

      a_val = kasumi_ref(iv, k ^ KEY_MOD);
      prev  = 64'd0;
      for (int n = 0; n < int'(nb); n++) begin
         prev = kasumi_ref(a_val ^ 64'(n) ^ prev, k);
         exp_blk.push_back(prev);
      end

      first_v = -1; prev_hs = -1; last_hs = -1; done_c = -1;
      done_cnt = 0; busy_cnt = 0; idx = 0; holding = 1'b0;
      held_data = 64'd0; held_din = 64'd0; held_last = 1'b0;
      budget = 300 + (int'(nb) + 2) * (LAT + 1) * 4;

      @(posedge clk); #1;
      start = 1'b1; kc = k; init_data = iv; num_blocks = nb;
      ks_ready = (mode == 1) ? 1'b0 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      c = 0;
      while (c < budget && (done_c < 0 || c < done_c + 3)) begin
         @(negedge clk);
         if (c == 0) check("busy_before_accept", 64'(busy), 64'd0);
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            if (done_c < 0) done_c = c;
         end
         if (nb != 8'd0 && c == LAT / 2) begin
            check("pre_core_kc", core_kc, k ^ KEY_MOD);
            check("pre_core_din", core_din, iv);
         end
         if (nb != 8'd0 && c == LAT + LAT / 2) check("gen_core_kc", core_kc, k);
         if (!ks_valid) begin
            holding = 1'b0;
         end else begin
            if (first_v < 0) first_v = c;
            if (ks_ready) begin
               holding = 1'b0;
               if (idx < exp_blk.size()) begin
                  check($sformatf("block%0d_data", idx), ks_data, exp_blk[idx]);
                  check($sformatf("block%0d_last", idx), 64'(ks_last), 64'(idx == int'(nb) - 1));
               end else begin
                  check("extra_block", 64'(idx), 64'(nb));
               end
               if ((mode == 0 || mode == 3) && prev_hs >= 0)
                  check("block_spacing", 64'(c - prev_hs), 64'(LAT + 1));
               prev_hs = c;
               last_hs = c;
               idx++;
            end else if (!holding) begin
               holding   = 1'b1;
               held_data = ks_data;
               held_din  = core_din;
               held_last = ks_last;
            end else begin
               check("stall_data_stable", ks_data, held_data);
               check("stall_last_stable", 64'(ks_last), 64'(held_last));
`ifndef A53_KS_OVERLAP_EN
               check("stall_core_din_stable", core_din, held_din);
`endif
            end
         end
         @(posedge clk); #1;
         c++;
         if (c == 1) begin
            // Accepted values must have been latched; scramble the inputs.
            start = 1'b0;
            kc = {$urandom, $urandom};
            init_data = {$urandom, $urandom};
            num_blocks = 8'($urandom_range(0, 255));
         end
         case (mode)
            1:       ks_ready = (first_v >= 0 && c >= first_v + 40);
            2:       ks_ready = 1'($urandom_range(0, 1));
            default: ks_ready = 1'b1;
         endcase
         if (mode == 3 && c == LAT + 3) begin
            start = 1'b1;
            kc = {$urandom, $urandom};
            init_data = {$urandom, $urandom};
            num_blocks = 8'd2;
         end
         if (mode == 3 && c == LAT + 4) start = 1'b0;
      end

      check("done_seen", 64'(done_c >= 0), 64'd1);
      check("done_pulse_count", 64'(done_cnt), 64'd1);
      check("blocks_delivered", 64'(idx), 64'(nb));
      if (nb == 8'd0) begin
         check("zero_no_valid", 64'(first_v < 0), 64'd1);
         check("zero_done_cycle", 64'(done_c), 64'd1);
         check("zero_busy_cycles", 64'(busy_cnt), 64'd1);
      end else begin
         check("done_after_last_hs", 64'(done_c), 64'(last_hs + 1));
         check("busy_cycles", 64'(busy_cnt), 64'(done_c));
         // first_v is the cycle ks_valid is seen; the edge after it is where the consumer takes it.
         if (mode == 0 || mode == 3)
            check("first_valid_latency", 64'(first_v + 1), 64'(2 * LAT + 2));
      end
   endtask

   int  abort_done_cnt;
   logic abort_seen;

   // Main stimulus sequence.
   initial begin
      rst = 1'b1; start = 1'b0; kc = 64'd0; init_data = 64'd0;
      num_blocks = 8'd0; ks_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_ks_valid", 64'(ks_valid), 64'd0);
      check("rst_ks_data", ks_data, 64'd0);
      check("rst_ks_last", 64'(ks_last), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_core_kc", core_kc, 64'd0);
      check("rst_core_din", core_din, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      run_seq(64'd0, 64'h1234, 8'd3, 0);          // basic chain and latency
      run_seq(64'd0, 64'h1234, 8'd3, 1);          // backpressure on block 1
      run_seq(64'd0, 64'h1234, 8'd0, 0);          // zero-length request
      run_seq(64'hDEAD_BEEF_0123_4567, 64'h0F0F_1234_5678_9ABC, 8'd3, 3);  // start while busy

      // Reset in the middle of the second block's wait.
      @(posedge clk); #1;
      start = 1'b1; kc = {$urandom, $urandom}; init_data = {$urandom, $urandom};
      num_blocks = 8'd3; ks_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      abort_seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (ks_valid) begin
            abort_seen = 1'b1;
            break;
         end
      end
      check("abort_first_valid", 64'(abort_seen), 64'd1);
      repeat (6) @(negedge clk);
      check("abort_in_gen_wait", 64'(busy && !ks_valid), 64'd1);
      #1 rst = 1'b1;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_ks_data", ks_data, 64'd0);
      check("abort_core_kc", core_kc, 64'd0);
      check("abort_core_din", core_din, 64'd0);
      check("abort_flags", {61'd0, ks_valid, ks_last, done}, 64'd0);
      abort_done_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (done) abort_done_cnt++;
      end
      check("abort_no_done", 64'(abort_done_cnt), 64'd0);
      rst = 1'b0;
      run_seq({$urandom, $urandom}, {$urandom, $urandom}, 8'd3, 0);

      // Randomised sequences with random consumer backpressure.
      for (int r = 0; r < 4; r++)
         run_seq({$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom_range(1, 6)), 2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
